// File: rtl/twi_pkg.sv
// Shared definitions for the AHB-to-TWI request sequencer: register offsets,
// sequencer states, and default cycle budgets derived from the master's timing.
package twi_pkg;

    // Word offsets decoded from HADDR[4:2]
    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_ADDR   = 3'd1;
    localparam logic [2:0] OFF_WDATA  = 3'd2;
    localparam logic [2:0] OFF_RDATA  = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } seq_state_t;

    // Timing of the downstream TWI master
    localparam int TWI_START_CYCLES = 95;
    localparam int TWI_STOP_CYCLES  = 95;
    localparam int TWI_BYTE_CYCLES  = 1135;

    // The request must outlive START but end well inside the first byte slot
    localparam int REQ_HOLD_DEF  = TWI_START_CYCLES + 5;
    // Write: START, chip, reg, data, STOP = 3595, rounded up with margin
    localparam int WR_CYCLES_DEF = TWI_START_CYCLES + 3 * TWI_BYTE_CYCLES
                                 + TWI_STOP_CYCLES + 105;
    // Read: START, chip, reg, repeated START, chip, data, STOP = 4825, plus margin
    localparam int RD_CYCLES_DEF = 2 * TWI_START_CYCLES + 4 * TWI_BYTE_CYCLES
                                 + TWI_STOP_CYCLES + 175;

    // Packs the STATUS register word
    function automatic logic [31:0] status_word(input logic busy,
                                                input logic done,
                                                input logic ovr);
        return {29'd0, ovr, done, busy};
    endfunction

endpackage

// File: rtl/twi_seq.sv
// Transaction sequencer: holds the wr/rd request for REQ_HOLD cycles, then
// waits out the rest of the budget and flags a one-cycle capture/done slot.
module twi_seq
    import twi_pkg::*;
#(
    parameter int REQ_HOLD  = REQ_HOLD_DEF,
    parameter int WR_CYCLES = WR_CYCLES_DEF,
    parameter int RD_CYCLES = RD_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start_wr,
    input  logic start_rd,
    output logic wr,
    output logic rd,
    output logic busy,
    output logic done,
    output logic capture_en
);

    localparam logic [15:0] HOLD_LAST = 16'(REQ_HOLD - 1);
    localparam logic [15:0] WR_LAST   = 16'(WR_CYCLES - 1);
    localparam logic [15:0] RD_LAST   = 16'(RD_CYCLES - 1);

    seq_state_t  state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic        op_rd_r, op_rd_s;
    logic        wr_r, wr_s;
    logic        rd_r, rd_s;

    // State, counter, op type and request strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 16'd0;
            op_rd_r <= 1'b0;
            wr_r    <= 1'b0;
            rd_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_rd_r <= op_rd_s;
            wr_r    <= wr_s;
            rd_r    <= rd_s;
        end
    end

    // Next-state, counter and strobe logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        op_rd_s = op_rd_r;
        case (state_r)
            IDLE: begin
                if (start_wr || start_rd) begin
                    op_rd_s = start_rd & ~start_wr;
                    cnt_s   = 16'd0;
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                cnt_s = cnt_r + 16'd1;
                if (cnt_r == HOLD_LAST) begin
                    state_s = RUN;
                end else begin
                    state_s = REQ;
                end
            end
            RUN: begin
                cnt_s = cnt_r + 16'd1;
                if (cnt_r == (op_rd_r ? RD_LAST : WR_LAST)) begin
                    state_s = CAPTURE;
                end else begin
                    state_s = RUN;
                end
            end
            CAPTURE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // Strobes are registered so they track the state register exactly
        wr_s = (state_s == REQ) & ~op_rd_s;
        rd_s = (state_s == REQ) &  op_rd_s;
    end

    assign wr         = wr_r;
    assign rd         = rd_r;
    assign busy       = (state_r != IDLE);
    assign done       = (state_r == CAPTURE);
    assign capture_en = (state_r == CAPTURE) & op_rd_r;

endmodule

// File: rtl/ahb_twi_ctrl.sv
// AHB-Lite register front end for the TWI master: decodes word accesses,
// holds the transaction fields stable while busy and reports status.
module ahb_twi_ctrl
    import twi_pkg::*;
#(
    parameter int REQ_HOLD  = REQ_HOLD_DEF,
    parameter int WR_CYCLES = WR_CYCLES_DEF,
    parameter int RD_CYCLES = RD_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [6:0]  chip_addr,
    output logic [7:0]  reg_addr,
    output logic [7:0]  datain,
    output logic        wr,
    output logic        rd,
    input  logic [7:0]  dataout
);

    logic [2:0] addr_r;
    logic       wphase_r;
    logic [6:0] chip_addr_r;
    logic [7:0] reg_addr_r;
    logic [7:0] datain_r;
    logic [7:0] rdata_r;
    logic       done_r;
    logic       ovr_r;

    logic ctrl_we_s, addr_we_s, wdata_we_s;
    logic start_any_s, start_wr_s, start_rd_s, ovr_set_s;
    logic busy_s, done_s, capture_en_s;
    logic unused_s;

    assign unused_s = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

    // Address phase capture; a stalled bus keeps the pending phase
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_r   <= 3'd0;
            wphase_r <= 1'b0;
        end else if (HREADY) begin
            addr_r   <= HADDR[4:2];
            wphase_r <= HSEL & HTRANS[1] & HWRITE;
        end
    end

    // Data-phase write decode and start/overrun qualification
    always_comb begin
        ctrl_we_s  = 1'b0;
        addr_we_s  = 1'b0;
        wdata_we_s = 1'b0;
        if (wphase_r) begin
            case (addr_r)
                OFF_CTRL:  ctrl_we_s  = 1'b1;
                OFF_ADDR:  addr_we_s  = 1'b1;
                OFF_WDATA: wdata_we_s = 1'b1;
                default:   ctrl_we_s  = 1'b0;
            endcase
        end else begin
            ctrl_we_s = 1'b0;
        end
        start_any_s = ctrl_we_s & (HWDATA[1:0] != 2'b00);
        start_wr_s  = start_any_s & ~busy_s & HWDATA[0];
        start_rd_s  = start_any_s & ~busy_s & ~HWDATA[0] & HWDATA[1];
        ovr_set_s   = busy_s & (start_any_s | addr_we_s | wdata_we_s);
    end

    // Register file and sticky status bits
    always_ff @(posedge clk) begin
        if (!rst) begin
            chip_addr_r <= 7'd0;
            reg_addr_r  <= 8'd0;
            datain_r    <= 8'd0;
            rdata_r     <= 8'd0;
            done_r      <= 1'b0;
            ovr_r       <= 1'b0;
        end else begin
            if (addr_we_s && !busy_s) begin
                chip_addr_r <= HWDATA[6:0];
                reg_addr_r  <= HWDATA[15:8];
            end
            if (wdata_we_s && !busy_s) begin
                datain_r <= HWDATA[7:0];
            end
            if (capture_en_s) begin
                rdata_r <= dataout;
            end
            if (start_wr_s || start_rd_s) begin
                done_r <= 1'b0;
                ovr_r  <= 1'b0;
            end else begin
                if (done_s)    done_r <= 1'b1;
                if (ovr_set_s) ovr_r  <= 1'b1;
            end
        end
    end

    // Read mux driven from the captured address for zero-wait reads
    always_comb begin
        HRDATA = 32'd0;
        case (addr_r)
            OFF_ADDR:   HRDATA = {16'd0, reg_addr_r, 1'b0, chip_addr_r};
            OFF_WDATA:  HRDATA = {24'd0, datain_r};
            OFF_RDATA:  HRDATA = {24'd0, rdata_r};
            OFF_STATUS: HRDATA = status_word(busy_s, done_r, ovr_r);
            default:    HRDATA = 32'd0;
        endcase
    end

    twi_seq #(
        .REQ_HOLD  (REQ_HOLD),
        .WR_CYCLES (WR_CYCLES),
        .RD_CYCLES (RD_CYCLES)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .start_wr   (start_wr_s),
        .start_rd   (start_rd_s),
        .wr         (wr),
        .rd         (rd),
        .busy       (busy_s),
        .done       (done_s),
        .capture_en (capture_en_s)
    );

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign chip_addr = chip_addr_r;
    assign reg_addr  = reg_addr_r;
    assign datain    = datain_r;

endmodule

// File: tb/tb_ahb_twi_ctrl.sv
// Directed bench for ahb_twi_ctrl with hand-computed expectations.
module tb_ahb_twi_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        HSEL, HWRITE, HREADY;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HREADYOUT, HRESP;
    logic [6:0]  chip_addr;
    logic [7:0]  reg_addr, datain, dataout;
    logic        wr, rd;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int wr_hi = 0, rd_hi = 0, wr_rise = 0, rd_rise = 0;
    logic wr_q = 1'b0, rd_q = 1'b0;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_ADDR   = 32'h04;
    localparam logic [31:0] A_WDATA  = 32'h08;
    localparam logic [31:0] A_RDATA  = 32'h0C;
    localparam logic [31:0] A_STATUS = 32'h10;
    localparam logic [31:0] A_UNMAP  = 32'h14;

    ahb_twi_ctrl dut (
        .clk(clk), .rst(rst), .HSEL(HSEL), .HWRITE(HWRITE), .HREADY(HREADY),
        .HTRANS(HTRANS), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .chip_addr(chip_addr),
        .reg_addr(reg_addr), .datain(datain), .wr(wr), .rd(rd), .dataout(dataout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitors: high-cycle counts and rising-edge counts
    always @(negedge clk) begin
        if (wr) wr_hi++;
        if (rd) rd_hi++;
        if (wr && !wr_q) wr_rise++;
        if (rd && !rd_q) rd_rise++;
        wr_q = wr;
        rd_q = rd;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Address phase in the next cycle, returns in the data phase cycle
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge clk); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    endtask

    // Read whose data phase lands exactly on cycle t
    task automatic bus_read_at(input logic [31:0] a, input int t, output logic [31:0] d);
        wait_until(t - 1);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge clk); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        check_eq("read_sched", cyc, t);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus_read_at(a, cyc + 1, d);
    endtask

    initial begin
        logic [31:0] d;
        int n, h0, r0, rh0, rr0;

        rst = 1'b0; HSEL = 1'b0; HWRITE = 1'b0; HREADY = 1'b1;
        HTRANS = 2'b00; HADDR = 32'd0; HWDATA = 32'd0; dataout = 8'h00;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_wr", wr, 1'b0);
        check_eq("rst_rd", rd, 1'b0);
        check_eq("rst_chip", chip_addr, 7'h00);
        check_eq("rst_reg", reg_addr, 8'h00);
        check_eq("rst_datain", datain, 8'h00);
        check_eq("rst_hrdata", HRDATA, 32'd0);
        check_eq("rst_hreadyout", HREADYOUT, 1'b1);
        check_eq("rst_hresp", HRESP, 1'b0);
        rst = 1'b1;
        bus_read(A_STATUS, d); check_eq("rst_status", d, 32'h0);
        bus_read(A_RDATA, d);  check_eq("rst_rdata", d, 32'h0);

        // CTRL with no start bits does nothing
        bus_write(A_CTRL, 32'h0);
        @(posedge clk); #1;
        check_eq("ctrl0_wr", wr, 1'b0);
        check_eq("ctrl0_rd", rd, 1'b0);
        bus_read(A_STATUS, d); check_eq("ctrl0_status", d, 32'h0);

        // Field setup, readback, unmapped access
        bus_write(A_ADDR, 32'h0000_3A50);
        bus_write(A_WDATA, 32'h0000_00C3);
        bus_write(A_UNMAP, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check_eq("chip_addr", chip_addr, 7'h50);
        check_eq("reg_addr", reg_addr, 8'h3A);
        check_eq("datain", datain, 8'hC3);
        bus_read(A_ADDR, d);  check_eq("addr_rb", d, 32'h0000_3A50);
        bus_read(A_WDATA, d); check_eq("wdata_rb", d, 32'h0000_00C3);
        bus_read(A_CTRL, d);  check_eq("ctrl_rb", d, 32'h0);
        bus_read(A_UNMAP, d); check_eq("unmap_rb", d, 32'h0);

        // Write transaction
        h0 = wr_hi; r0 = wr_rise; rh0 = rd_hi;
        bus_write(A_CTRL, 32'h1);
        n = cyc;
        @(posedge clk); #1;
        check_eq("w_wr_on", wr, 1'b1);
        check_eq("w_rd_off", rd, 1'b0);
        bus_read_at(A_STATUS, n + 2, d);    check_eq("w_busy", d, 32'h1);
        bus_read_at(A_STATUS, n + 3701, d); check_eq("w_capture", d, 32'h1);
        bus_read_at(A_STATUS, n + 3702, d); check_eq("w_done", d, 32'h2);
        check_eq("w_wr_len", wr_hi - h0, 32'd100);
        check_eq("w_wr_pulses", wr_rise - r0, 32'd1);
        check_eq("w_rd_len", rd_hi - rh0, 32'd0);

        // Read transaction
        bus_write(A_ADDR, 32'h0000_0750);
        dataout = 8'h5A;
        h0 = wr_hi; rh0 = rd_hi;
        bus_write(A_CTRL, 32'h2);
        n = cyc;
        @(posedge clk); #1;
        check_eq("r_rd_on", rd, 1'b1);
        check_eq("r_wr_off", wr, 1'b0);
        check_eq("r_chip", chip_addr, 7'h50);
        check_eq("r_reg", reg_addr, 8'h07);
        bus_read_at(A_STATUS, n + 2, d);    check_eq("r_busy", d, 32'h1);
        bus_read_at(A_RDATA, n + 5001, d);  check_eq("r_rdata_pre", d, 32'h0);
        bus_read_at(A_STATUS, n + 5002, d); check_eq("r_done", d, 32'h2);
        bus_read_at(A_RDATA, n + 5003, d);  check_eq("r_rdata", d, 32'h5A);
        check_eq("r_rd_len", rd_hi - rh0, 32'd100);
        check_eq("r_wr_len", wr_hi - h0, 32'd0);

        // Overrun: restart and field write while busy
        r0 = wr_rise;
        bus_write(A_CTRL, 32'h1);
        n = cyc;
        bus_read_at(A_STATUS, n + 2, d); check_eq("o_busy", d, 32'h1);
        wait_until(n + 199);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_ADDR, 32'h0000_1111);
        @(posedge clk); #1;
        check_eq("o_chip", chip_addr, 7'h50);
        check_eq("o_reg", reg_addr, 8'h07);
        bus_read(A_STATUS, d); check_eq("o_status", d, 32'h5);
        bus_read(A_ADDR, d);   check_eq("o_addr_rb", d, 32'h0000_0750);
        bus_read_at(A_STATUS, n + 3702, d); check_eq("o_done", d, 32'h6);
        check_eq("o_wr_pulses", wr_rise - r0, 32'd1);

        // Both start bits: write wins, and the start clears done/ovr
        rr0 = rd_rise;
        bus_write(A_CTRL, 32'h3);
        n = cyc;
        @(posedge clk); #1;
        check_eq("b_wr_on", wr, 1'b1);
        check_eq("b_rd_off", rd, 1'b0);
        bus_read_at(A_STATUS, n + 2, d);    check_eq("b_clear", d, 32'h1);
        bus_read_at(A_STATUS, n + 3702, d); check_eq("b_done", d, 32'h2);
        check_eq("b_rd_pulses", rd_rise - rr0, 32'd0);

        // Reset mid-RUN of a read
        dataout = 8'hA5;
        bus_write(A_CTRL, 32'h2);
        n = cyc;
        wait_until(n + 50);
        check_eq("m_rd_req", rd, 1'b1);
        wait_until(n + 1500);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_eq("m_rd_off", rd, 1'b0);
        check_eq("m_wr_off", wr, 1'b0);
        check_eq("m_chip", chip_addr, 7'h00);
        bus_read(A_STATUS, d); check_eq("m_status", d, 32'h0);
        bus_read(A_RDATA, d);  check_eq("m_rdata", d, 32'h0);
        wait_until(n + 5200);
        bus_read(A_RDATA, d);  check_eq("m_rdata_late", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
